// File: rtl/neuron_potential_integrator.sv
// Time-multiplexed membrane potential integrator: one neuron per clock per tick,
// with saturation, threshold fire/reset, negative floor and spike/done events.
module neuron_potential_integrator #(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned POT_W       = 16,
    parameter int          THRESHOLD   = 100,
    parameter int          RESET_POT   = 0,
    parameter int          NEG_FLOOR   = -100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [7:0]       leak_value,
    input  logic [7:0]       syn_in,
    output logic [IDX_W-1:0] neuron_idx,
    output logic             busy,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_idx,
    output logic             done,
    output logic             overrun
);

    localparam int unsigned SUM_W = POT_W + 2;
    localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'((2 ** (POT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO   = ~SAT_HI;
    localparam logic signed [POT_W-1:0] THR_P    = POT_W'(THRESHOLD);
    localparam logic signed [POT_W-1:0] RST_P    = POT_W'(RESET_POT);
    localparam logic signed [POT_W-1:0] FLOOR_P  = POT_W'(NEG_FLOOR);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic signed [POT_W-1:0] pot [NUM_NEURONS];
    logic signed [7:0]       leak_reg;

    logic signed [SUM_W-1:0] sum;
    logic signed [POT_W-1:0] sum_sat;
    logic signed [POT_W-1:0] pot_next;
    logic                    fire;

    logic [IDX_W-1:0]        idx_next;
    logic                    busy_next;
    logic                    spike_valid_next;
    logic [IDX_W-1:0]        spike_idx_next;
    logic                    done_next;
    logic                    overrun_next;
    logic                    leak_load;
    logic                    pot_we;

    // Datapath for the neuron currently addressed: add, saturate, fire/floor
    always_comb begin
        sum      = SUM_W'(pot[neuron_idx]) + SUM_W'($signed(syn_in)) + SUM_W'(leak_reg);
        sum_sat  = POT_W'(sum);
        fire     = 1'b0;
        pot_next = sum_sat;
        if (sum > SAT_HI) begin
            sum_sat = POT_W'(SAT_HI);
        end else if (sum < SAT_LO) begin
            sum_sat = POT_W'(SAT_LO);
        end
        if (sum_sat >= THR_P) begin
            fire     = 1'b1;
            pot_next = RST_P;
        end else if (sum_sat < FLOOR_P) begin
            pot_next = FLOOR_P;
        end else begin
            pot_next = sum_sat;
        end
    end

    // Next-state and next-output decode for the sweep controller
    always_comb begin
        state_next       = state;
        idx_next         = neuron_idx;
        busy_next        = busy;
        spike_valid_next = 1'b0;
        spike_idx_next   = spike_idx;
        done_next        = 1'b0;
        overrun_next     = 1'b0;
        leak_load        = 1'b0;
        pot_we           = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = UPDATE;
                    idx_next   = '0;
                    busy_next  = 1'b1;
                    leak_load  = 1'b1;
                end
            end
            UPDATE: begin
                pot_we       = 1'b1;
                overrun_next = tick;
                if (fire) begin
                    spike_valid_next = 1'b1;
                    spike_idx_next   = neuron_idx;
                end
                if (neuron_idx == LAST_IDX) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    idx_next = neuron_idx + IDX_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            neuron_idx  <= '0;
            busy        <= 1'b0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            leak_reg    <= '0;
        end else begin
            state       <= state_next;
            neuron_idx  <= idx_next;
            busy        <= busy_next;
            spike_valid <= spike_valid_next;
            spike_idx   <= spike_idx_next;
            done        <= done_next;
            overrun     <= overrun_next;
            if (leak_load) begin
                leak_reg <= $signed(leak_value);
            end
        end
    end

    // Potential storage; only the addressed neuron is written during a sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                pot[i] <= '0;
            end
        end else if (pot_we) begin
            pot[neuron_idx] <= pot_next;
        end
    end

endmodule

// File: tb/tb_neuron_potential_integrator.sv
// Self-checking bench: cycle scoreboard for the default instance, table-driven
// sweep vectors, hand sequences for leak capture, overrun, reset and saturation.
module tb_neuron_potential_integrator;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, tick_a, tick_b;
    logic [7:0] leak_value, syn_in;
    logic [1:0] neuron_idx_a, spike_idx_a, neuron_idx_b, spike_idx_b;
    logic       busy_a, spike_valid_a, done_a, overrun_a;
    logic       busy_b, spike_valid_b, done_b, overrun_b;

    int checks   = 0;
    int failures = 0;
    int spk_a = 0, done_cnt_a = 0, ovr_cnt_a = 0, spk_b = 0;

    always #5 clk = ~clk;

    neuron_potential_integrator dut_a (
        .clk(clk), .rst(rst_a), .tick(tick_a), .leak_value(leak_value), .syn_in(syn_in),
        .neuron_idx(neuron_idx_a), .busy(busy_a), .spike_valid(spike_valid_a),
        .spike_idx(spike_idx_a), .done(done_a), .overrun(overrun_a)
    );

    neuron_potential_integrator #(.POT_W(9), .THRESHOLD(255)) dut_b (
        .clk(clk), .rst(rst_b), .tick(tick_b), .leak_value(leak_value), .syn_in(syn_in),
        .neuron_idx(neuron_idx_b), .busy(busy_b), .spike_valid(spike_valid_b),
        .spike_idx(spike_idx_b), .done(done_b), .overrun(overrun_b)
    );

    typedef struct {
        logic [1:0] idx;
        logic       busy;
        logic       sv;
        logic [1:0] sidx;
        logic       done;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];

    // Reference model of instance A: one expected output record per clock edge
    initial begin : model
        int   m_v[4];
        int   m_idx, m_leak, s;
        bit   m_busy;
        exp_t e;
        m_v = '{0, 0, 0, 0};
        m_idx = 0; m_leak = 0; m_busy = 0;
        e = '{idx: 2'd0, busy: 1'b0, sv: 1'b0, sidx: 2'd0, done: 1'b0, ov: 1'b0};
        forever begin
            @(posedge clk);
            e.sv = 1'b0; e.done = 1'b0; e.ov = 1'b0;
            if (rst_a) begin
                m_v = '{0, 0, 0, 0};
                m_idx = 0; m_leak = 0; m_busy = 0;
                e.sidx = 2'd0;
            end else if (!m_busy) begin
                if (tick_a) begin
                    m_busy = 1; m_idx = 0;
                    m_leak = int'($signed(leak_value));
                end
            end else begin
                e.ov = tick_a;
                s = m_v[m_idx] + int'($signed(syn_in)) + m_leak;
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                if (s >= 100) begin
                    m_v[m_idx] = 0;
                    e.sv = 1'b1;
                    e.sidx = 2'(m_idx);
                end else if (s < -100) begin
                    m_v[m_idx] = -100;
                end else begin
                    m_v[m_idx] = s;
                end
                if (m_idx == 3) begin
                    m_busy = 0; m_idx = 0; e.done = 1'b1;
                end else begin
                    m_idx++;
                end
            end
            e.idx = 2'(m_idx);
            e.busy = m_busy;
            exp_q.push_back(e);
        end
    end

    // Scoreboard compare and event counters, sampled mid-cycle
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (spike_valid_a) spk_a++;
            if (done_a) done_cnt_a++;
            if (overrun_a) ovr_cnt_a++;
            if (spike_valid_b) spk_b++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (neuron_idx_a !== e.idx || busy_a !== e.busy || spike_valid_a !== e.sv ||
                    done_a !== e.done || overrun_a !== e.ov ||
                    (e.sv && spike_idx_a !== e.sidx)) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t got idx=%0d busy=%0b sv=%0b sidx=%0d done=%0b ov=%0b want idx=%0d busy=%0b sv=%0b sidx=%0d done=%0b ov=%0b",
                             $time, neuron_idx_a, busy_a, spike_valid_a, spike_idx_a, done_a, overrun_a,
                             e.idx, e.busy, e.sv, e.sidx, e.done, e.ov);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, req);
        end
    endtask

    task automatic wait_done(input bit sel);
        bit seen = 0;
        for (int c = 0; c < 12; c++) begin
            if ((sel ? done_b : done_a) === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout inst=%0d got=0 want=1", sel);
        end
    endtask

    task automatic run_sweep(input bit sel);
        @(negedge clk);
        if (sel) tick_b = 1'b1; else tick_a = 1'b1;
        @(negedge clk);
        tick_a = 1'b0; tick_b = 1'b0;
        wait_done(sel);
        @(negedge clk);
    endtask

    task automatic pulse_rst(input bit sel);
        @(negedge clk);
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    typedef struct {
        bit         do_rst;
        logic [7:0] syn;
        logic [7:0] leak;
        int         ticks;
        int         exp_spikes;
    } vec_t;

    initial begin : stimulus
        vec_t vecs[8];
        int   base, dbase, obase;

        vecs[0] = '{do_rst: 1, syn: 8'd0,   leak: 8'h01, ticks: 1,   exp_spikes: 0};
        vecs[1] = '{do_rst: 1, syn: 8'd60,  leak: 8'h00, ticks: 1,   exp_spikes: 0};
        vecs[2] = '{do_rst: 0, syn: 8'd60,  leak: 8'h00, ticks: 1,   exp_spikes: 4};
        vecs[3] = '{do_rst: 0, syn: 8'd0,   leak: 8'hFF, ticks: 150, exp_spikes: 0};
        vecs[4] = '{do_rst: 0, syn: 8'd0,   leak: 8'hFF, ticks: 3,   exp_spikes: 0};
        vecs[5] = '{do_rst: 0, syn: 8'd127, leak: 8'h00, ticks: 1,   exp_spikes: 0};
        vecs[6] = '{do_rst: 0, syn: 8'd73,  leak: 8'h00, ticks: 1,   exp_spikes: 4};
        vecs[7] = '{do_rst: 0, syn: 8'd127, leak: 8'h7F, ticks: 1,   exp_spikes: 4};

        rst_a = 1'b1; rst_b = 1'b1; tick_a = 1'b0; tick_b = 1'b0;
        leak_value = 8'h00; syn_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven sweeps on the default instance
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_rst) pulse_rst(1'b0);
            syn_in = vecs[i].syn;
            leak_value = vecs[i].leak;
            base = spk_a;
            dbase = done_cnt_a;
            for (int t = 0; t < vecs[i].ticks; t++) run_sweep(1'b0);
            check($sformatf("vec%0d_spikes", i), spk_a - base, vecs[i].exp_spikes);
            check($sformatf("vec%0d_dones", i), done_cnt_a - dbase, vecs[i].ticks);
        end

        // Leak is captured at the tick edge and held for the sweep
        pulse_rst(1'b0);
        syn_in = 8'd0; leak_value = 8'h01;
        base = spk_a;
        @(negedge clk); tick_a = 1'b1;
        @(negedge clk); tick_a = 1'b0;
        @(negedge clk); leak_value = 8'h7F;
        wait_done(1'b0);
        @(negedge clk);
        check("leak_hold_spikes", spk_a - base, 0);
        base = spk_a;
        run_sweep(1'b0);
        check("leak_next_spikes", spk_a - base, 4);

        // Tick while busy is dropped; tick during done starts a new sweep
        pulse_rst(1'b0);
        syn_in = 8'd0; leak_value = 8'h00;
        dbase = done_cnt_a; obase = ovr_cnt_a;
        @(negedge clk); tick_a = 1'b1;
        @(negedge clk); tick_a = 1'b0;
        @(negedge clk); tick_a = 1'b1;
        @(negedge clk); tick_a = 1'b0;
        wait_done(1'b0);
        tick_a = 1'b1;
        @(negedge clk); tick_a = 1'b0;
        wait_done(1'b0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("overrun_count", ovr_cnt_a - obase, 1);
        check("done_count", done_cnt_a - dbase, 2);

        // Reset mid-sweep aborts the sweep and clears every potential
        pulse_rst(1'b0);
        syn_in = 8'd0; leak_value = 8'h20;
        run_sweep(1'b0);
        base = spk_a; dbase = done_cnt_a;
        @(negedge clk); tick_a = 1'b1;
        @(negedge clk); tick_a = 1'b0;
        @(negedge clk); rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_dones", done_cnt_a - dbase, 0);
        check("abort_spikes", spk_a - base, 0);
        syn_in = 8'd60; leak_value = 8'h00;
        run_sweep(1'b0);
        check("post_rst_spikes", spk_a - base, 0);

        // Narrow instance: saturation must clamp rather than wrap
        pulse_rst(1'b1);
        syn_in = 8'd127; leak_value = 8'h7F;
        base = spk_b;
        run_sweep(1'b1);
        check("sat_sweep1_spikes", spk_b - base, 0);
        base = spk_b;
        run_sweep(1'b1);
        check("sat_sweep2_spikes", spk_b - base, 4);
        base = spk_b;
        run_sweep(1'b1);
        check("sat_sweep3_spikes", spk_b - base, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_potential_integrator.md
Name: neuron_potential_integrator

Overview:
- Downstream consumer of the leak reversal stage.
- Holds membrane potentials for NUM_NEURONS time-multiplexed neurons. On each tick it sweeps every neuron once, one neuron per clock, and applies: synaptic input + signed leak, saturation, threshold/fire, reset and negative floor.
- Emits one registered spike event per firing neuron, then a done pulse.

Parameters:
- NUM_NEURONS, 4, neurons swept per tick (>=2).
- IDX_W, 2, width of neuron index; must equal clog2(NUM_NEURONS).
- POT_W, 16, signed membrane potential width (>=9).
- THRESHOLD, 100, signed firing threshold; fire when potential >= THRESHOLD.
- RESET_POT, 0, signed potential loaded after a spike.
- NEG_FLOOR, -100, signed lower clamp for potential.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  start-of-timestep pulse.
- leak_value  input  8  signed two's-complement leak from the leak reversal stage.
- syn_in  input  8  signed synaptic sum for neuron_idx; combinational from upstream, valid in the same cycle.
- neuron_idx  output  IDX_W  neuron currently being updated.
- busy  output  1  sweep in progress.
- spike_valid  output  1  one-cycle spike event.
- spike_idx  output  IDX_W  index of the spiking neuron; valid with spike_valid.
- done  output  1  one-cycle pulse when the sweep completes.
- overrun  output  1  one-cycle pulse when a tick arrives while busy.

Behaviour:
- Reset: all potentials = 0, state IDLE, neuron_idx = 0. busy, spike_valid, spike_idx, done and overrun all = 0.
- States: IDLE, UPDATE.
- IDLE -> UPDATE when tick = 1 at an edge.
  - leak_value is captured into leak_reg at that edge and held for the whole sweep. Mid-sweep changes to leak_value are ignored.
  - neuron_idx = 0 and busy = 1 from that edge.
- In UPDATE, each edge updates neuron k = neuron_idx:
  - sum = v[k] + sext(syn_in) + sext(leak_reg), computed at POT_W+2 bits.
  - Saturate sum to [-2^(POT_W-1), 2^(POT_W-1)-1].
  - If saturated sum >= THRESHOLD: v[k] <= RESET_POT; spike_valid = 1 and spike_idx = k in the following cycle.
  - Else if saturated sum < NEG_FLOOR: v[k] <= NEG_FLOOR.
  - Else: v[k] <= saturated sum.
  - neuron_idx increments after each update.
- On the edge that updates neuron NUM_NEURONS-1: state -> IDLE, neuron_idx -> 0, busy -> 0, done = 1 for one cycle.
  - That done cycle coincides with the spike_valid for the last neuron, if it fired.
- Latency:
  - Tick sampled at edge E0.
  - Neuron k is updated at edge E(k+1).
  - done is high in the cycle after edge E(NUM_NEURONS).
  - Total sweep = NUM_NEURONS cycles.
- Tick while busy: the sweep continues unaffected and leak_reg is unchanged. overrun = 1 for the cycle after that edge; the tick is dropped, not queued.
- Tick in the same cycle done is high: accepted normally, since the state is IDLE by then.
- spike_valid and done are registered; they are never high for more than one cycle per event.
- Potentials persist across ticks; only rst clears them.
- rst mid-sweep:
  - Immediate return to the reset state; all potentials cleared.
  - No done and no further spikes for the aborted sweep.
- Untouched neurons retain their values: no neuron is updated outside UPDATE.

Test Plan:
1. Defaults. Reset, then leak_value = 0x01, syn_in = 0, one tick -> neuron_idx steps 0..3 on consecutive cycles; done exactly 4 cycles after the tick edge; all potentials = 1; no spike_valid.
2. syn_in = 60, leak_value = 0x00. Tick 1 -> all potentials = 60, no spikes. Tick 2 -> sums = 120 >= 100: spike_valid on 4 consecutive cycles with spike_idx 0,1,2,3; potentials = 0.
3. syn_in = 0, leak_value = 0xFF (-1). After 150 ticks -> potentials clamp at -100 and stay at -100 on further ticks; no spikes.
4. Leak capture. Change leak_value from 0x01 to 0x7F two cycles after the tick edge -> the sweep still adds +1 to every neuron; the next tick uses +127.
5. Overrun. Assert tick again at cycle 2 of a sweep -> overrun pulses once; done occurs only once, at the original time; no second sweep starts.
6. Saturation, with POT_W = 9 and THRESHOLD = 255. Repeated syn_in = 127, leak_value = 0x7F -> potential saturates at 255, fires, and resets to 0.
   - Separately, asserting rst mid-sweep -> busy = 0 the next cycle, no done, all potentials = 0.
